// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-cycle data memory.
// Port A is the CPU MEM stage, port B the loader/debug port. Each transaction runs
// arbitrate (IDLE or DONE) -> ACCESS (gnt + memory strobe) -> DONE (rvalid/err).
// Optional feature macro: DMEM_ARB_LOCK_EN adds input b_lock so B can keep winning
// arbitration for burst preloads while it holds the last grant.
module dmem_arbiter #(
    parameter int ADDR_LIMIT = 40,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic          a_err,
    output logic [AW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [AW-1:0] b_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          b_lock,
`endif
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic          b_err,
    output logic [AW-1:0] b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [AW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          win_q;      // 0 = A, 1 = B
    logic          last_q;     // port that won the most recent arbitration
    logic          we_q;
    logic          err_q;      // latched address was illegal
    logic [AW-1:0] addr_q, wdata_q;
    logic [AW-1:0] a_rdata_q, b_rdata_q;

    logic          arb_en, pick_b, sel_illegal;
    logic [AW-1:0] sel_addr, rd_val;
    logic          in_access, in_done;

    assign in_access = (state_q == S_ACCESS);
    assign in_done   = (state_q == S_DONE);

    // Winner selection: a lone requester wins; on a tie the port that did not win last goes.
    always_comb begin
        pick_b = b_req && (!a_req || !last_q);
`ifdef DMEM_ARB_LOCK_EN
        if (last_q && b_req && b_lock) pick_b = 1'b1;
`endif
        arb_en      = (state_q == S_IDLE || state_q == S_DONE) && (a_req || b_req);
        sel_addr    = pick_b ? b_addr : a_addr;
        sel_illegal = (sel_addr[1:0] != 2'b00) || (sel_addr > AW'(ADDR_LIMIT));
    end

    // Next state: every accepted request spends one cycle in ACCESS and one in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (a_req || b_req) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = (a_req || b_req) ? S_ACCESS : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register; reset leaves B as last winner so A takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (arb_en) begin
                win_q  <= pick_b;
                last_q <= pick_b;
            end
        end
    end

    // Capture the winning request so the requester may release it after gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (arb_en) begin
            we_q    <= pick_b ? b_we    : a_we;
            addr_q  <= sel_addr;
            wdata_q <= pick_b ? b_wdata : a_wdata;
            err_q   <= sel_illegal;
        end
    end

    // Only legal reads return memory data; writes and faulted accesses return zero.
    assign rd_val = (we_q || err_q) ? '0 : mem_rdata;

    // Per-port read data, updated only for the port being served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (in_access) begin
            if (win_q) b_rdata_q <= rd_val;
            else       a_rdata_q <= rd_val;
        end
    end

    assign a_gnt     = in_access && !win_q;
    assign b_gnt     = in_access &&  win_q;
    assign a_rvalid  = in_done && !win_q;
    assign b_rvalid  = in_done &&  win_q;
    assign a_err     = a_rvalid && err_q;
    assign b_err     = b_rvalid && err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    // Strobes decode straight from state so an async reset drops them immediately.
    assign mem_we    = in_access &&  we_q && !err_q;
    assign mem_re    = in_access && !we_q && !err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (default ADDR_LIMIT=40, AW=32).
// Build with DMEM_ARB_LOCK_EN defined to also exercise the B lock feature.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, busy;
`ifdef DMEM_ARB_LOCK_EN
    logic        b_lock = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Bench memory: 16 words, cleared while reset is held, optional read override.
    logic [31:0] mem [16];
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    assign mem_rdata = ovr_en ? ovr_val : mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .b_lock(b_lock),
`endif
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, mem_we, mem_re, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000000",
                     {a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, mem_we, mem_re, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, a_rdata, b_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero",
                     mem_addr, mem_wdata, a_rdata, b_rdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic();
        ovr_en = 1'b1; ovr_val = 32'h1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd8;
        @(posedge clk); #1;
        checks++;
        if ({a_gnt, b_gnt, mem_re, mem_we} !== 4'b1010 || mem_addr !== 32'd8) begin
            errors++;
            $display("FAIL read_access: got gnt/re/we=%b addr=%0h expected 1010 addr=8",
                     {a_gnt, b_gnt, mem_re, mem_we}, mem_addr);
        end
        a_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a_rvalid, a_err, b_rvalid} !== 3'b100 || a_rdata !== 32'h1) begin
            errors++;
            $display("FAIL read_done: got rv/err/brv=%b rdata=%h expected 100 rdata=1",
                     {a_rvalid, a_err, b_rvalid}, a_rdata);
        end
        ovr_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || a_gnt !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: got busy=%b gnt=%b expected 0 0", busy, a_gnt);
        end
    endtask

    task automatic test_illegal();
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd6; b_wdata = 32'hDEAD;
        @(posedge clk); #1;
        checks++;
        if ({b_gnt, mem_we, mem_re} !== 3'b100) begin
            errors++;
            $display("FAIL misalign_access: got gnt/we/re=%b expected 100", {b_gnt, mem_we, mem_re});
        end
        b_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({b_rvalid, b_err} !== 2'b11 || b_rdata !== 32'h0) begin
            errors++;
            $display("FAIL misalign_done: got rv/err=%b rdata=%h expected 11 rdata=0",
                     {b_rvalid, b_err}, b_rdata);
        end
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd44; a_wdata = 32'h1234;
        @(posedge clk); #1;
        checks++;
        if ({a_gnt, mem_we, mem_re} !== 3'b100) begin
            errors++;
            $display("FAIL range_access: got gnt/we/re=%b expected 100", {a_gnt, mem_we, mem_re});
        end
        a_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a_rvalid, a_err} !== 2'b11 || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL range_done: got rv/err=%b rdata=%h expected 11 rdata=0",
                     {a_rvalid, a_err}, a_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_max();
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd0; a_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        checks++;
        if ({a_gnt, mem_we, mem_re} !== 3'b110 || mem_addr !== 32'd0 || mem_wdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL write_access: got gnt/we/re=%b addr=%h wdata=%h expected 110 0 ffffffff",
                     {a_gnt, mem_we, mem_re}, mem_addr, mem_wdata);
        end
        a_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({mem_we, a_rvalid, a_err} !== 3'b010 || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL write_done: got we/rv/err=%b rdata=%h expected 010 rdata=0",
                     {mem_we, a_rvalid, a_err}, a_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd4;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            exp_g = 2'b00;
            if (c % 2 == 1) exp_g = (((c - 1) / 2) % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({a_gnt, b_gnt} !== exp_g) begin
                errors++;
                $display("FAIL rr_cycle%0d: got a/b gnt=%b expected %b", c, {a_gnt, b_gnt}, exp_g);
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: got busy=%b expected 0", busy);
        end
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_g;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        b_lock = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd4;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            exp_g = 2'b00;
            if (c % 2 == 1) exp_g = (c < 7) ? 2'b01 : 2'b10;
            checks++;
            if ({a_gnt, b_gnt} !== exp_g) begin
                errors++;
                $display("FAIL lock_cycle%0d: got a/b gnt=%b expected %b", c, {a_gnt, b_gnt}, exp_g);
            end
            if (c == 5) b_lock = 1'b0;
        end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_reset_mid_access();
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd12; a_wdata = 32'h5;
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got mem_we=%b expected 1", mem_we);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, busy, a_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_async: got we/busy/gnt=%b expected 000", {mem_we, busy, a_gnt});
        end
        a_req = 1'b0;
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({a_rvalid, b_rvalid, busy} !== 3'b000) begin
                errors++;
                $display("FAIL rstmid_after%0d: got rv_a/rv_b/busy=%b expected 000",
                         c, {a_rvalid, b_rvalid, busy});
            end
        end
    endtask

    function automatic logic [31:0] gen_addr();
        int k;
        k = $urandom_range(0, 15);
        if (k < 11)  return 32'(k * 4);
        if (k == 11) return 32'd44;
        if (k == 12) return 32'd60;
        return 32'($urandom_range(0, 9) * 4 + $urandom_range(1, 3));
    endfunction

    // Transaction-level model: pending request per port, round-robin by last winner,
    // a word array for memory contents and the last returned data per port.
    task automatic test_random();
        logic [31:0] mdl [16];
        logic [31:0] mrd [2];
        logic        pend [2];
        logic        twe [2];
        logic [31:0] tad [2];
        logic [31:0] twd [2];
        logic [1:0]  one_hot;
        logic        legal;
        int          last, win, n, p;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        mrd[0] = '0; mrd[1] = '0; pend[0] = 1'b0; pend[1] = 1'b0; last = 1;
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int t = 0; t < 80; t++) begin
            for (int q = 0; q < 2; q++) begin
                if (!pend[q] && $urandom_range(0, 1) == 1) begin
                    pend[q] = 1'b1; twe[q] = 1'($urandom_range(0, 1));
                    tad[q] = gen_addr(); twd[q] = $urandom;
                end
            end
            if (!pend[0] && !pend[1]) begin
                p = $urandom_range(0, 1);
                pend[p] = 1'b1; twe[p] = 1'($urandom_range(0, 1));
                tad[p] = gen_addr(); twd[p] = $urandom;
            end
            a_req = pend[0]; a_we = twe[0]; a_addr = tad[0]; a_wdata = twd[0];
            b_req = pend[1]; b_we = twe[1]; b_addr = tad[1]; b_wdata = twd[1];
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (!a_gnt && !b_gnt && n < 10);
            if (!a_gnt && !b_gnt) begin
                checks++; errors++;
                $display("FAIL rnd_timeout%0d: got no gnt within %0d cycles expected a gnt", t, n);
                break;
            end
            win = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
            one_hot = (win == 1) ? 2'b01 : 2'b10;
            legal = (tad[win][1:0] == 2'b00) && (tad[win] <= 32'd40);
            checks++;
            if ({a_gnt, b_gnt} !== one_hot) begin
                errors++;
                $display("FAIL rnd_gnt%0d: got a/b=%b expected %b", t, {a_gnt, b_gnt}, one_hot);
            end
            checks++;
            if ({mem_we, mem_re} !== {legal && twe[win], legal && !twe[win]} ||
                (legal && mem_addr !== tad[win]) || (legal && twe[win] && mem_wdata !== twd[win])) begin
                errors++;
                $display("FAIL rnd_mem%0d: got we/re=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                         t, {mem_we, mem_re}, mem_addr, mem_wdata, legal && twe[win], tad[win], twd[win]);
            end
            mrd[win] = (legal && !twe[win]) ? mdl[tad[win][5:2]] : 32'h0;
            if (legal && twe[win]) mdl[tad[win][5:2]] = twd[win];
            last = win; pend[win] = 1'b0;
            if (win == 1) b_req = 1'b0; else a_req = 1'b0;
            @(posedge clk); #1;
            checks++;
            if ({a_rvalid, b_rvalid} !== one_hot ||
                {a_err, b_err} !== (legal ? 2'b00 : one_hot) ||
                a_rdata !== mrd[0] || b_rdata !== mrd[1]) begin
                errors++;
                $display("FAIL rnd_done%0d: got rv=%b err=%b rd=%h/%h expected rv=%b err=%b rd=%h/%h",
                         t, {a_rvalid, b_rvalid}, {a_err, b_err}, a_rdata, b_rdata,
                         one_hot, legal ? 2'b00 : one_hot, mrd[0], mrd[1]);
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_illegal();
        test_write_max();
        test_round_robin();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 40, the highest legal word-aligned byte address.
REQ-002 SHALL have parameter AW, default 32, the address/data width of all ports.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on the posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports a_req/a_we  in  1 each  CPU MEM-stage request and write-enable.
REQ-006 SHALL have ports a_addr/a_wdata  in  32 each  CPU byte address and write data.
REQ-007 SHALL have ports a_gnt/a_rvalid/a_err  out  1 each  grant, completion and error pulses to the CPU.
REQ-008 SHALL have port a_rdata  out  32  CPU read data.
REQ-009 SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_err, b_rdata identical to the a_* ports, serving the loader/debug port.
REQ-010 SHALL have ports mem_addr/mem_wdata  out  32 each  and mem_we/mem_re  out  1 each, driving the data memory.
REQ-011 SHALL have port mem_rdata  in  32  combinational memory read data.
REQ-012 SHALL have port busy  out  1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-014 SHALL arbitrate in IDLE and DONE: if one req is high, pick it; if both, pick the port not in last_gnt (round-robin).
REQ-015 SHALL, on arbitration, latch the winner's we/addr/wdata and the winner id, update last_gnt, and enter ACCESS next cycle.
REQ-016 SHALL, in ACCESS, pulse the winner's gnt for exactly one cycle and drive mem_addr/mem_wdata from the latched values.
REQ-017 SHALL, in ACCESS, assert mem_we (write) or mem_re (read) for exactly one cycle, only for legal addresses.
REQ-018 SHALL treat an address as illegal if addr[1:0] != 0 or addr > ADDR_LIMIT; no memory strobe is issued.
REQ-019 SHALL register mem_rdata at the end of ACCESS into the winner's rdata; writes and errors leave rdata at 0.
REQ-020 SHALL, in DONE, pulse the winner's rvalid for one cycle, plus err if the address was illegal.
REQ-021 SHALL go from DONE to ACCESS if any req is high, else to IDLE; requests sampled in DONE are accepted back-to-back.
REQ-022 SHALL hold the non-winner's rdata unchanged, and hold mem_* strobes at 0 outside ACCESS.
REQ-023 SHALL require requesters to hold req/we/addr/wdata stable until their gnt; latency is req-to-gnt 1 cycle uncontended and req-to-rvalid 2 cycles.
REQ-024 SHALL ignore a req that drops before grant without side effects.

Reset
REQ-025 SHALL, on rst_n low, force IDLE and last_gnt=B (A wins first tie), and clear all gnt/rvalid/err, mem_we, mem_re and busy.
REQ-026 SHALL, on rst_n low, clear mem_addr, mem_wdata, a_rdata and b_rdata to 0.
REQ-027 SHALL, on reset mid-ACCESS, de-assert mem_we at once; no completion pulse follows reset.

Configuration
REQ-028 SHALL, when macro DMEM_ARB_LOCK_EN is defined, add input b_lock (1 bit); while B holds the last grant and b_req & b_lock, B wins arbitration regardless of round-robin (burst preload).
REQ-029 SHALL, without DMEM_ARB_LOCK_EN, have no b_lock port and use pure round-robin.

Verification
REQ-030 SHALL cover: A read of addr 8 with mem_rdata=0x1 -> a_gnt in cycle 1, mem_re in cycle 1, a_rvalid and a_rdata=0x1 in cycle 2.
REQ-031 SHALL cover: A and B requesting together after reset, both held -> order A, B, A, B; a gnt every 2 cycles.
REQ-032 SHALL cover: B write addr 6 -> no mem_we, b_err and b_rvalid in DONE, b_rdata=0; A write addr 44 with ADDR_LIMIT=40 -> a_err.
REQ-033 SHALL cover: A write 0xFFFFFFFF to addr 0 -> mem_we for one cycle with mem_addr=0 and mem_wdata=0xFFFFFFFF.
REQ-034 SHALL cover: rst_n low during ACCESS of a write -> mem_we falls asynchronously, busy=0, no rvalid after release.
REQ-035 SHALL cover, with DMEM_ARB_LOCK_EN: b_lock=1 and both requesting -> B granted 3 times consecutively; b_lock=0 -> A next.
